apu_dma_arbiter: RTL

- Sits between the 6502 core and the system bus in the 2A03 top level.
- Steals CPU bus cycles through the core's ready input to perform two kinds of transfer:
  - sprite (OAM) DMA: 256 bytes from page $XX00 to $2004, triggered by a CPU write to $4014.
  - single-byte DMC sample fetches requested by the APU.
- Arbitrates the bus between core, OAM channel and DMC channel at CPU-cycle granularity.

---
 rtl/apu_dma_arbiter_if.sv | 27 ++
 rtl/apu_dma_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/apu_dma_arbiter_if.sv
// CPU-side and bus-side signals of the 2A03 DMA arbiter.
// master = core/bus/APU side, slave = arbiter.
interface apu_dma_arbiter_if;
    logic        I_cycle;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_wr_data;
    logic        I_cpu_rdwr;
    logic [7:0]  I_rd_data;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic        O_ready;
    logic        I_dmc_req;
    logic [15:0] I_dmc_addr;
    logic [7:0]  O_dmc_data;
    logic        O_dmc_ack;

    modport master (
        output I_cycle, I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data, I_dmc_req, I_dmc_addr,
        input  O_addr, O_wr_data, O_rdwr, O_ready, O_dmc_data, O_dmc_ack
    );

    modport slave (
        input  I_cycle, I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data, I_dmc_req, I_dmc_addr,
        output O_addr, O_wr_data, O_rdwr, O_ready, O_dmc_data, O_dmc_ack
    );
endinterface

// File: rtl/apu_dma_arbiter.sv
// Steals 6502 bus cycles via RDY for sprite (OAM) DMA and DMC sample fetches.
// All state advances on the end-of-CPU-cycle strobe; bus outputs are combinational.
module apu_dma_arbiter #(
    parameter logic [15:0] OAM_TRIGGER = 16'h4014,
    parameter logic [15:0] OAM_TARGET  = 16'h2004
) (
    input logic               I_clock,
    input logic               I_reset,
    apu_dma_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StHalt, StAlign, StXfer, StDone} state_e;

    state_e      state_q, state_d;
    logic        parity_q, parity_d;  // 0 = GET cycle, 1 = PUT cycle
    logic [7:0]  page_q, page_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  latch_q, latch_d;
    logic [7:0]  dmc_data_q, dmc_data_d;
    logic        oam_active_q, oam_active_d;
    logic        get_oam_q, get_oam_d;  // previous GET fetched an OAM byte
    logic        dmc_ack_q, dmc_ack_d;
    logic        trigger;

    assign trigger = bus.I_cycle && !bus.I_cpu_rdwr && (bus.I_cpu_addr == OAM_TRIGGER) &&
                     !oam_active_q;

    always_comb begin
        state_d      = state_q;
        parity_d     = parity_q;
        page_d       = page_q;
        count_d      = count_q;
        latch_d      = latch_q;
        dmc_data_d   = dmc_data_q;
        oam_active_d = oam_active_q;
        get_oam_d    = get_oam_q;
        dmc_ack_d    = 1'b0;
        if (bus.I_cycle) begin
            parity_d  = ~parity_q;
            get_oam_d = 1'b0;
            if (trigger) begin
                page_d       = bus.I_cpu_wr_data;
                count_d      = 8'h00;
                oam_active_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (oam_active_q || trigger || bus.I_dmc_req) state_d = StHalt;
                end
                StHalt: begin
                    // A halt on GET leaves the next cycle on PUT, so one align cycle is needed.
                    if (bus.I_cpu_rdwr) state_d = parity_q ? StXfer : StAlign;
                end
                StAlign: state_d = StXfer;
                StXfer: begin
                    if (!parity_q) begin
                        if (bus.I_dmc_req) begin
                            dmc_data_d = bus.I_rd_data;
                            dmc_ack_d  = 1'b1;
                        end else if (oam_active_q) begin
                            latch_d   = bus.I_rd_data;
                            get_oam_d = 1'b1;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        if (get_oam_q) begin
                            count_d = count_q + 8'd1;
                            if (count_q == 8'hFF) oam_active_d = 1'b0;
                        end
                        if (!bus.I_dmc_req && !oam_active_d) state_d = StDone;
                    end
                end
                StDone:  state_d = bus.I_dmc_req ? StHalt : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            state_q      <= StIdle;
            parity_q     <= 1'b0;
            page_q       <= 8'h00;
            count_q      <= 8'h00;
            latch_q      <= 8'h00;
            dmc_data_q   <= 8'h00;
            oam_active_q <= 1'b0;
            get_oam_q    <= 1'b0;
            dmc_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            parity_q     <= parity_d;
            page_q       <= page_d;
            count_q      <= count_d;
            latch_q      <= latch_d;
            dmc_data_q   <= dmc_data_d;
            oam_active_q <= oam_active_d;
            get_oam_q    <= get_oam_d;
            dmc_ack_q    <= dmc_ack_d;
        end
    end

    always_comb begin
        bus.O_addr    = bus.I_cpu_addr;
        bus.O_wr_data = bus.I_cpu_wr_data;
        bus.O_rdwr    = bus.I_cpu_rdwr;
        bus.O_ready   = 1'b1;
        case (state_q)
            StHalt: bus.O_ready = 1'b0;
            StAlign: begin
                bus.O_ready = 1'b0;
                bus.O_rdwr  = 1'b1;
            end
            StXfer: begin
                bus.O_ready = 1'b0;
                if (!parity_q) begin
                    if (bus.I_dmc_req) begin
                        bus.O_addr = bus.I_dmc_addr;
                        bus.O_rdwr = 1'b1;
                    end else if (oam_active_q) begin
                        bus.O_addr = {page_q, count_q};
                        bus.O_rdwr = 1'b1;
                    end
                end else if (get_oam_q) begin
                    bus.O_addr    = OAM_TARGET;
                    bus.O_rdwr    = 1'b0;
                    bus.O_wr_data = latch_q;
                end else begin
                    bus.O_rdwr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.O_dmc_data = dmc_data_q;
    assign bus.O_dmc_ack  = dmc_ack_q;
endmodule
